// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multi-word CLA sequencer: word width, FSM states,
// and the lookahead/overflow helper functions.
package cla_seq_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Carries into bits 0..3 of a 4-bit lookahead block.
  function automatic logic [3:0] cla4_carry(input logic [3:0] g, input logic [3:0] p,
                                            input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Block generate of a 4-bit lookahead group.
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/adder16_reg.sv
// Two-level 16-bit carry-lookahead adder with registered sum/carry-out;
// results appear one edge after an enabled input sample.
module adder16_reg
  import cla_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_cin,
  output logic [WORD_W-1:0] o_sum,
  output logic              o_cout
);

  logic [WORD_W-1:0] w_g;
  logic [WORD_W-1:0] w_p;
  logic [WORD_W-1:0] w_c;
  logic [3:0]        w_gg;
  logic [3:0]        w_gp;
  logic [3:0]        w_gc;
  logic              w_cout;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    assign w_gg[j]          = grp_gen(w_g[4*j +: 4], w_p[4*j +: 4]);
    assign w_gp[j]          = &w_p[4*j +: 4];
    assign w_c[4*j +: 4]    = cla4_carry(w_g[4*j +: 4], w_p[4*j +: 4], w_gc[j]);
  end

  // Second lookahead level resolves the carry into each 4-bit group.
  assign w_gc   = cla4_carry(w_gg, w_gp, i_cin);
  assign w_cout = grp_gen(w_gg, w_gp) | ((&w_gp) & i_cin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sum  <= '0;
      o_cout <= 1'b0;
    end else if (i_en) begin
      o_sum  <= w_p ^ w_c;
      o_cout <= w_cout;
    end
  end

endmodule

// File: rtl/cla_multiword_seq.sv
// Multi-precision add/subtract: one registered 16-bit CLA reused per word,
// LSW first, with the inter-word carry held in a flag register.
module cla_multiword_seq
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sub,
  input  logic [WORD_W*WORDS-1:0] op_a,
  input  logic [WORD_W*WORDS-1:0] op_b,
  output logic                    busy,
  output logic                    done,
  output logic [WORD_W*WORDS-1:0] result,
  output logic                    cout,
  output logic                    overflow
);

  localparam int N     = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e            r_state;
  logic [N-1:0]      r_a;
  logic [N-1:0]      r_b;
  logic              r_sub;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic [N-1:0]      r_result;
  logic              r_busy;
  logic              r_done;
  logic              r_cout;
  logic              r_ovf;

  logic [WORD_W-1:0] w_a_word;
  logic [WORD_W-1:0] w_bx_word;
  logic [WORD_W-1:0] w_sum;
  logic              w_cout;
  logic              w_last;

  assign w_a_word  = r_a[r_idx*WORD_W +: WORD_W];
  assign w_bx_word = r_b[r_idx*WORD_W +: WORD_W] ^ {WORD_W{r_sub}};
  assign w_last    = (r_idx == IDX_W'(WORDS - 1));

  adder16_reg u_adder (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == ST_ISSUE),
    .i_a    (w_a_word),
    .i_b    (w_bx_word),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // NOTE: every register here is assigned with <= so all updates in a cycle
  // see the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= sub;
            r_idx   <= '0;
            r_carry <= sub;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: r_state <= ST_CAPT;
        ST_CAPT: begin
          r_result[r_idx*WORD_W +: WORD_W] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            // Adder inputs still select the top word, so its MSBs are live.
            r_cout  <= w_cout;
            r_ovf   <= signed_ovf(w_a_word[WORD_W-1], w_bx_word[WORD_W-1],
                                  w_sum[WORD_W-1]);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed self-checking bench for cla_multiword_seq with WORDS=4 (64-bit ops).
module tb_cla_multiword_seq;

  localparam int N = 64;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cla_multiword_seq #(.WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op, scramble inputs after acceptance, and wait (bounded) for done.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        output int edges, output int busy_cnt);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
    edges    = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic check_outputs(input string name, input logic [N-1:0] exp_res,
                               input logic exp_cout, input logic exp_ovf);
    n_checks++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL %s_result: got %h expected %h", name, result, exp_res);
    end
    n_checks++;
    if (cout !== exp_cout) begin
      n_fail++;
      $display("FAIL %s_cout: got %b expected %b", name, cout, exp_cout);
    end
    n_checks++;
    if (overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s_overflow: got %b expected %b", name, overflow, exp_ovf);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: got %b expected 0", name, busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got %b expected 0", name, done);
    end
    check_outputs(name, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    #1 rst = 1'b1;
    #1 check_zero_outputs("reset_t0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ripple();
    int edges, bc;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, edges, bc);
    n_checks++;
    if (edges !== 8) begin
      n_fail++;
      $display("FAIL ripple_latency: got %0d edges expected 8", edges);
    end
    n_checks++;
    if (bc !== 8) begin
      n_fail++;
      $display("FAIL ripple_busy_cycles: got %0d expected 8", bc);
    end
    check_outputs("ripple", 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_borrow();
    int edges, bc;
    run_op(64'h0000_0000_0001_0000, 64'h1, 1'b1, edges, bc);
    check_outputs("borrow", 64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
  endtask

  task automatic test_negative();
    int edges, bc;
    run_op(64'h5, 64'h7, 1'b1, edges, bc);
    check_outputs("negative", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, edges, bc);
    check_outputs("signed_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
  endtask

  task automatic test_busy_protect();
    int dones = 0;
    @(negedge clk);
    op_a = 64'h10; op_b = 64'h20; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        start = 1'b1; op_a = 64'h1234; op_b = 64'h1;
      end
      if (i == 4) start = 1'b0;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL busy_protect_dones: got %0d expected 1", dones);
    end
    check_outputs("busy_protect", 64'h30, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int seen = 0;
    @(negedge clk);
    op_a = 64'h5555; op_b = 64'h1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_stays_idle: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int edges = 0;
    @(negedge clk);
    op_a = 64'h9999; op_b = 64'h9999; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (edges !== 8) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d edges expected 8", edges);
    end
    check_outputs("b2b_first", 64'h1_3332, 1'b0, 1'b0);
    op_a = 64'h3; op_b = 64'h4;
    @(posedge clk); #1;
    start = 1'b0; op_a = '0; op_b = '0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept_in_done: busy got %b expected 1", busy);
    end
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (edges !== 8) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d edges expected 8", edges);
    end
    check_outputs("b2b_second", 64'h7, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_borrow();
    test_negative();
    test_busy_protect();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
